// File: rtl/x25519_pkg.sv
// rtl/x25519_pkg.sv - shared field widths and constants for the X25519 reduction path
package x25519_pkg;

  // Canonical field element width (bit 255 of a residue is always zero).
  localparam int FIELD_W = 255;
  // Unreduced adder sum width.
  localparam int SUM_W = 264;
  // Width of a reduced field element as carried on buses.
  localparam int OUT_W = 256;
  // Bits of the sum that lie above the field width and must be folded down.
  localparam int HI_W = SUM_W - FIELD_W;

  // 2^255 == 19 (mod p), so anything above bit 254 folds back with weight 19.
  localparam int FOLD_CONST = 19;

  // p = 2^255 - 19
  localparam logic [OUT_W-1:0] P =
    256'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;

  typedef logic [OUT_W-1:0] fe_t;

endpackage

// File: rtl/x25519_fold19.sv
// rtl/x25519_fold19.sv - combinational lo + 19*hi fold for reduction mod 2^255-19
module x25519_fold19
  import x25519_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [N-1:0]       hi,
  input  logic [FIELD_W-1:0] lo,
  output logic [OUT_W-1:0]   sum
);

  // 19*hi needs at most N+5 bits (19 < 32).
  logic [N+4:0] hi_ext;
  logic [N+4:0] hi19;

  // Shift-and-add multiply by 19 = 16 + 2 + 1, then add the low part.
  always_comb begin
    hi_ext = (N+5)'(hi);
    hi19   = (hi_ext << 4) + (hi_ext << 1) + hi_ext;
    sum    = {1'b0, lo} + OUT_W'(hi19);
  end

endmodule

// File: rtl/x25519_reduce_sum.sv
// rtl/x25519_reduce_sum.sv - 3-stage pipelined reduction of a 264-bit sum to a canonical residue mod 2^255-19
module x25519_reduce_sum
  import x25519_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SUM_W-1:0] a,
  output logic             out_valid,
  output fe_t              out
);

  // Stage 1: fold the 9 bits above 2^255 into the low part.
  fe_t  t_next;
  fe_t  t;
  logic v1;

  // Stage 2: fold the single possible carry bit at 2^255.
  fe_t  u_next;
  fe_t  u;
  logic v2;

  // Stage 3: one conditional subtract of p; u < p + 38 after two folds.
  logic [OUT_W:0] d;
  fe_t            r_next;

  x25519_fold19 #(
    .N(HI_W)
  ) fold_hi (
    .hi (a[SUM_W-1:FIELD_W]),
    .lo (a[FIELD_W-1:0]),
    .sum(t_next)
  );

  x25519_fold19 #(
    .N(1)
  ) fold_carry (
    .hi (t[OUT_W-1]),
    .lo (t[FIELD_W-1:0]),
    .sum(u_next)
  );

  // Borrow out of the 257-bit subtract means u < p and u is already canonical.
  always_comb begin
    d      = {1'b0, u} - {1'b0, P};
    r_next = d[OUT_W] ? u : d[OUT_W-1:0];
  end

  // Stage 1 register: first fold result and its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      t  <= '0;
    end else begin
      v1 <= en;
      if (en) begin
        t <= t_next;
      end
    end
  end

  // Stage 2 register: second fold result and its valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      u  <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        u <= u_next;
      end
    end
  end

  // Output register: canonical residue, held while no new result arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_x25519_reduce_sum.sv
// tb/tb_x25519_reduce_sum.sv - self-checking bench for x25519_reduce_sum
module tb_x25519_reduce_sum;

  localparam logic [255:0] P =
    256'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;

  logic         clk;
  logic         rst;
  logic         en;
  logic [263:0] a;
  logic         out_valid;
  logic [255:0] out;

  int errors;
  int checks;
  int cyc;

  logic         en_ring [8];
  logic [263:0] a_ring  [8];

  logic [263:0] kv [7];
  logic [255:0] ke [7];

  x25519_reduce_sum dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .a        (a),
    .out_valid(out_valid),
    .out      (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] ref_mod(input logic [263:0] x);
    logic [263:0] m;
    m = {8'h0, P};
    return 256'(x % m);
  endfunction

  function automatic logic [263:0] rand_a();
    logic [263:0] v;
    logic [263:0] mask;
    v = '0;
    for (int w = 0; w < 9; w++) v = (v << 32) | 264'($urandom);
    mask = (264'd1 << 257) - 264'd1;
    v = v & mask;
    case ($urandom_range(0, 7))
      0: v = {8'h0, P} + 264'($urandom_range(0, 40));
      1: v = ({8'h0, P} << 1) - 264'($urandom_range(0, 40));
      2: v = 264'($urandom_range(0, 100));
      default: ;
    endcase
    return v;
  endfunction

  task automatic cycle(input logic r, input logic e, input logic [263:0] val);
    @(negedge clk);
    rst = r;
    en  = e;
    a   = val;
    en_ring[cyc % 8] = e && !r;
    a_ring[cyc % 8]  = val;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, rand_a());
    cycle(1'b1, 1'b1, rand_a());
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out !== 256'h0) begin
      errors++;
      $display("FAIL reset_out got=%h exp=0", out);
    end
    for (int j = 0; j < 3; j++) begin
      cycle(1'b0, 1'b0, '0);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_valid j=%0d got=%b exp=0", j, out_valid);
      end
    end
  endtask

  task automatic test_known();
    kv[0] = '0;                          ke[0] = 256'h0;
    kv[1] = {8'h0, P};                   ke[1] = 256'h0;
    kv[2] = {8'h0, P} + 264'd5;          ke[2] = 256'h5;
    kv[3] = 264'd1 << 255;               ke[3] = 256'h13;
    kv[4] = {8'h0, P} << 1;              ke[4] = 256'h0;
    kv[5] = ({8'h0, P} << 1) - 264'd1;   ke[5] = P - 256'd1;
    kv[6] = {264{1'b1}};                 ke[6] = 256'h25ff;
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, kv[i]);
      for (int j = 1; j <= 4; j++) begin
        cycle(1'b0, 1'b0, '0);
        checks++;
        if (out_valid !== (j == 2)) begin
          errors++;
          $display("FAIL known_valid vec=%0d cyc+%0d got=%b exp=%b", i, j + 1, out_valid, (j == 2));
        end
        if (j >= 2) begin
          checks++;
          if (out !== ke[i]) begin
            errors++;
            $display("FAIL known_out vec=%0d cyc+%0d got=%h exp=%h", i, j + 1, out, ke[i]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    for (int c = 0; c < 12; c++) begin
      cycle(1'b0, c < 7, (c < 7) ? kv[c] : 264'h0);
      idx = c - 2;
      checks++;
      if (out_valid !== (idx >= 0 && idx < 7)) begin
        errors++;
        $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, out_valid, (idx >= 0 && idx < 7));
      end
      if (idx >= 0 && idx < 7) begin
        checks++;
        if (out !== ke[idx]) begin
          errors++;
          $display("FAIL b2b_out idx=%0d got=%h exp=%h", idx, out, ke[idx]);
        end
      end
    end
  endtask

  task automatic test_random();
    int           n_en;
    int           n_valid;
    int           sent;
    logic         exp_v;
    logic [255:0] exp_o;
    logic [255:0] hold;
    logic         have_hold;
    logic         e;
    n_en = 0;
    n_valid = 0;
    sent = 0;
    have_hold = 1'b0;
    hold = '0;
    while (sent < 10000 || en_ring[(cyc - 3) % 8] || en_ring[(cyc - 2) % 8] || en_ring[(cyc - 1) % 8]) begin
      e = (sent < 10000) && ($urandom_range(0, 3) != 0);
      cycle(1'b0, e, e ? rand_a() : 264'h0);
      if (e) begin
        sent++;
        n_en++;
      end
      exp_v = en_ring[(cyc - 3) % 8];
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v);
      end
      if (out_valid === 1'b1) n_valid++;
      if (exp_v) begin
        exp_o = ref_mod(a_ring[(cyc - 3) % 8]);
        hold = exp_o;
        have_hold = 1'b1;
        checks++;
        if (out !== exp_o) begin
          errors++;
          $display("FAIL rand_out a=%h got=%h exp=%h", a_ring[(cyc - 3) % 8], out, exp_o);
        end
      end else if (have_hold) begin
        checks++;
        if (out !== hold) begin
          errors++;
          $display("FAIL rand_hold got=%h exp=%h", out, hold);
        end
      end
    end
    checks++;
    if (n_valid != n_en) begin
      errors++;
      $display("FAIL rand_count valid=%0d en=%0d", n_valid, n_en);
    end
  endtask

  task automatic test_reset_mid();
    logic [263:0] x0;
    logic [263:0] x1;
    logic [263:0] x2;
    logic [263:0] x3;
    for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, '0);
    x0 = rand_a();
    x1 = rand_a();
    x2 = rand_a();
    x3 = rand_a();
    cycle(1'b0, 1'b1, x0);
    cycle(1'b0, 1'b1, x1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre_valid got=%b exp=0", out_valid);
    end
    cycle(1'b0, 1'b1, x2);
    checks++;
    if (out_valid !== 1'b1 || out !== ref_mod(x0)) begin
      errors++;
      $display("FAIL mid_first got_v=%b got=%h exp=%h", out_valid, out, ref_mod(x0));
    end
    cycle(1'b1, 1'b1, rand_a());
    checks++;
    if (out_valid !== 1'b0 || out !== 256'h0) begin
      errors++;
      $display("FAIL mid_rst got_v=%b got=%h exp_v=0 exp=0", out_valid, out);
    end
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 1'b0, '0);
      checks++;
      if (out_valid !== 1'b0 || out !== 256'h0) begin
        errors++;
        $display("FAIL mid_dropped j=%0d got_v=%b got=%h exp_v=0 exp=0", j, out_valid, out);
      end
    end
    cycle(1'b0, 1'b1, x3);
    for (int j = 1; j <= 3; j++) begin
      cycle(1'b0, 1'b0, '0);
      checks++;
      if (out_valid !== (j == 2)) begin
        errors++;
        $display("FAIL mid_after_valid cyc+%0d got=%b exp=%b", j + 1, out_valid, (j == 2));
      end
      if (j == 2) begin
        checks++;
        if (out !== ref_mod(x3)) begin
          errors++;
          $display("FAIL mid_after_out got=%h exp=%h", out, ref_mod(x3));
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc = 0;
    rst = 1'b1;
    en = 1'b0;
    a = '0;
    for (int i = 0; i < 8; i++) begin
      en_ring[i] = 1'b0;
      a_ring[i] = '0;
    end
    test_reset();
    test_known();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
